// File: rtl/regbag_if.sv
// rtl/regbag_if.sv - MEM/WB write port and ID-stage read ports of the integer register file
interface regbag_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regbag_w_en;
  logic [ADDR_W-1:0] regbag_w_addr;
  logic [DATA_W-1:0] regbag_w_data;
  logic              s_flag_i;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;

  modport master (
    output regbag_w_en, regbag_w_addr, regbag_w_data, s_flag_i, r_addr1, r_addr2,
    input  r_data1, r_data2
  );

  modport slave (
    input  regbag_w_en, regbag_w_addr, regbag_w_data, s_flag_i, r_addr1, r_addr2,
    output r_data1, r_data2
  );
endinterface

// File: rtl/regbag_rf.sv
// rtl/regbag_rf.sv - RISC-V integer register file with post-reset clear engine, x0 hardwired to zero
// Optional REGBAG_BYPASS_EN: write-first forwarding of a committing write onto matching read ports.
module regbag_rf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  regbag_if.slave     bus,
  output logic        init_done,
  output logic [15:0] wr_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_idx, clr_idx_n;
  logic              commit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_idx <= '0;
      wr_cnt  <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
      if (commit) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    mem_we    = 1'b0;
    mem_waddr = bus.regbag_w_addr;
    mem_wdata = bus.regbag_w_data;
    commit    = (state == RUN) && bus.regbag_w_en && !bus.s_flag_i &&
                (bus.regbag_w_addr != '0);
    case (state)
      INIT: begin
        // The clear engine owns the single write port; offered writes are dropped.
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        clr_idx_n = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_IDX) state_n = RUN;
      end
      RUN: begin
        mem_we = commit;
      end
      default: state_n = INIT;
    endcase
  end

  // Storage has no reset; it is zeroed by the clear engine once rst_n releases.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign init_done = (state == RUN);

  always_comb begin
    bus.r_data1 = mem[bus.r_addr1];
`ifdef REGBAG_BYPASS_EN
    if (commit && (bus.r_addr1 == bus.regbag_w_addr)) bus.r_data1 = bus.regbag_w_data;
`endif
    if ((state != RUN) || (bus.r_addr1 == '0)) bus.r_data1 = '0;
  end

  always_comb begin
    bus.r_data2 = mem[bus.r_addr2];
`ifdef REGBAG_BYPASS_EN
    if (commit && (bus.r_addr2 == bus.regbag_w_addr)) bus.r_data2 = bus.regbag_w_data;
`endif
    if ((state != RUN) || (bus.r_addr2 == '0)) bus.r_data2 = '0;
  end

endmodule
